// File: rtl/mux_arb_pkg.sv
// Shared constants and state encoding for the 16:1 mux round-robin arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mux_arb_pkg;

    localparam int NREQ  = 16;
    localparam int SEL_W = 4;
    localparam int CNT_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick16.sv
// Round-robin winner search over 16 requests, starting just after the last owner.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result is valid whenever any is high.
module rr_pick16
    import mux_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    logic [SEL_W-1:0]  start;
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [SEL_W-1:0]  idx;

    // Rotate right by last+1 so bit 0 of rot is the highest-priority requester.
    assign start = last + SEL_W'(1);
    assign dbl   = {req, req} >> start;
    assign rot   = dbl[NREQ-1:0];

    // Find-first-set: scan downward so the lowest set bit is the one left in idx.
    always_comb begin
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) idx = SEL_W'(i);
        end
    end

    // Undo the rotation; 4-bit wrap gives the modulo-16 add for free.
    assign winner = idx + start;
    assign any    = |req;

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter owning the select lines of a shared 16:1 mux.
// Latency: grant one edge after req seen in IDLE; release one edge after done/drop/hold-limit.
// Backpressure: waiting requesters simply hold req; the hold limit bounds each owner's tenure.
module mux16_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic [NREQ-1:0]  grant,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             preempt
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [SEL_W-1:0] last, last_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic [NREQ-1:0]  grant_nxt;
    logic             preempt_nxt;

    logic [SEL_W-1:0] pick_winner;
    logic             pick_any;
    logic             at_limit;
    logic             others;
    logic             rel;

    rr_pick16 u_pick (
        .req    (req),
        .last   (last),
        .winner (pick_winner),
        .any    (pick_any)
    );

    // Release conditions for the current owner; grant is one-hot at sel while owning.
    assign at_limit = (cnt == HOLD_LIM);
    assign others   = |(req & ~grant);
    assign rel      = done | ~req[sel] | (at_limit & others);
    assign busy     = |grant;

    // Next-state and next-output logic: arbitrate in IDLE, watch for release in OWN.
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        sel_nxt     = sel;
        last_nxt    = last;
        cnt_nxt     = cnt;
        preempt_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nxt = ST_OWN;
                    sel_nxt   = pick_winner;
                    grant_nxt = NREQ'(1) << pick_winner;
                    cnt_nxt   = '0;
                end
            end
            ST_OWN: begin
                if (rel) begin
                    state_nxt   = ST_IDLE;
                    grant_nxt   = '0;
                    last_nxt    = sel;
                    // Only a forced revoke counts: owner still wants it and did not finish.
                    preempt_nxt = at_limit & others & ~done & req[sel];
                end else if (!at_limit) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // State and output registers; reset restores last=15 so the first search starts at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            grant   <= '0;
            sel     <= '0;
            last    <= '1;
            cnt     <= '0;
            preempt <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            sel     <= sel_nxt;
            last    <= last_nxt;
            cnt     <= cnt_nxt;
            preempt <= preempt_nxt;
        end
    end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
module tb_mux16_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        done;

    logic [15:0] grant_a, grant_b;
    logic [3:0]  sel_a, sel_b;
    logic        busy_a, busy_b;
    logic        preempt_a, preempt_b;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] grant;
        logic [3:0]  sel;
        logic        busy;
        logic        preempt;
        int          which;
        string       tag;
    } exp_t;

    exp_t sb[$];

    // dut_a: short hold limit used by most scenarios; dut_b: default hold limit.
    mux16_rr_arbiter #(.MAX_HOLD(4)) dut_a (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(grant_a), .sel(sel_a), .busy(busy_a), .preempt(preempt_a)
    );

    mux16_rr_arbiter dut_b (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(grant_b), .sel(sel_b), .busy(busy_b), .preempt(preempt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then check them.
    task automatic step(input logic r, input logic [15:0] rq, input logic d, input int which,
                        input logic [15:0] eg, input logic [3:0] es, input logic eb,
                        input logic ep, input string tag);
        exp_t e;
        e.grant = eg; e.sel = es; e.busy = eb; e.preempt = ep; e.which = which; e.tag = tag;
        sb.push_back(e);
        rst  = r;
        req  = rq;
        done = d;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.which == 0) begin
            cmp({e.tag, ".grant"},   grant_a,            e.grant);
            cmp({e.tag, ".sel"},     {12'd0, sel_a},     {12'd0, e.sel});
            cmp({e.tag, ".busy"},    {15'd0, busy_a},    {15'd0, e.busy});
            cmp({e.tag, ".preempt"}, {15'd0, preempt_a}, {15'd0, e.preempt});
        end else begin
            cmp({e.tag, ".grant"},   grant_b,            e.grant);
            cmp({e.tag, ".sel"},     {12'd0, sel_b},     {12'd0, e.sel});
            cmp({e.tag, ".busy"},    {15'd0, busy_b},    {15'd0, e.busy});
            cmp({e.tag, ".preempt"}, {15'd0, preempt_b}, {15'd0, e.preempt});
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; done = 1'b0;

        // Reset state and single request / done
        step(1, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, "reset_a");
        step(0, 16'h0001, 0, 0, 16'h0001, 0, 1, 0, "t1_grant0");
        step(0, 16'h0001, 1, 0, 16'h0000, 0, 0, 0, "t1_done");

        // Alternation 0 <-> 15 with wrap; first grant to 15 proves last was 0
        step(0, 16'h8001, 0, 0, 16'h8000, 15, 1, 0, "t2_g15a");
        step(0, 16'h8001, 1, 0, 16'h0000, 15, 0, 0, "t2_rel15a");
        step(0, 16'h8001, 0, 0, 16'h0001, 0, 1, 0, "t2_g0_wrap");
        step(0, 16'h8001, 1, 0, 16'h0000, 0, 0, 0, "t2_rel0");
        step(0, 16'h8001, 0, 0, 16'h8000, 15, 1, 0, "t2_g15b");
        step(0, 16'h8001, 1, 0, 16'h0000, 15, 0, 0, "t2_rel15b");
        step(0, 16'h0000, 0, 0, 16'h0000, 15, 0, 0, "t2_idle_sel_hold");

        // Hold limit 4 with two contenders
        for (int i = 0; i < 4; i++)
            step(0, 16'h0006, 0, 0, 16'h0002, 1, 1, 0, "t3_own1");
        step(0, 16'h0006, 0, 0, 16'h0000, 1, 0, 1, "t3_preempt1");
        for (int i = 0; i < 4; i++)
            step(0, 16'h0006, 0, 0, 16'h0004, 2, 1, 0, "t3_own2");
        step(0, 16'h0006, 0, 0, 16'h0000, 2, 0, 1, "t3_preempt2");
        step(0, 16'h0006, 0, 0, 16'h0002, 1, 1, 0, "t3_back_to1");
        step(0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, "t3_drop1");

        // Lone requester keeps the grant past the limit; newcomer preempts it
        for (int i = 0; i < 12; i++)
            step(0, 16'h0008, 0, 0, 16'h0008, 3, 1, 0, "t4_sat3");
        step(0, 16'h0028, 0, 0, 16'h0000, 3, 0, 1, "t4_preempt3");
        step(0, 16'h0028, 0, 0, 16'h0020, 5, 1, 0, "t4_grant5");

        // Owner drops request without done; pointer must follow
        step(0, 16'h0080, 0, 0, 16'h0000, 5, 0, 0, "t5_drop5");
        step(0, 16'h0080, 0, 0, 16'h0080, 7, 1, 0, "t5_grant7");
        step(0, 16'h0080, 0, 0, 16'h0080, 7, 1, 0, "t5_hold7");
        step(0, 16'h0000, 0, 0, 16'h0000, 7, 0, 0, "t5_drop7");
        step(0, 16'h0081, 0, 0, 16'h0001, 0, 1, 0, "t5_rot_to0");
        step(0, 16'h0081, 1, 0, 16'h0000, 0, 0, 0, "t5_done0");

        // Reset mid-grant restores last=15
        step(0, 16'h0200, 0, 0, 16'h0200, 9, 1, 0, "t6_grant9");
        step(0, 16'h0200, 0, 0, 16'h0200, 9, 1, 0, "t6_hold9");
        step(1, 16'h0200, 0, 0, 16'h0000, 0, 0, 0, "t6_reset");
        step(0, 16'hFFFF, 0, 0, 16'h0001, 0, 1, 0, "t6_after_rst0");
        step(0, 16'hFFFF, 1, 0, 16'h0000, 0, 0, 0, "t6_done0");
        step(0, 16'hFFFF, 0, 0, 16'h0002, 1, 1, 0, "t6_next1");

        // done coinciding with the hold limit is a normal release
        for (int i = 0; i < 3; i++)
            step(0, 16'hFFFF, 0, 0, 16'h0002, 1, 1, 0, "t7_own1");
        step(0, 16'hFFFF, 1, 0, 16'h0000, 1, 0, 0, "t7_done_at_limit");
        step(0, 16'hFFFF, 0, 0, 16'h0004, 2, 1, 0, "t7_next2");

        // Default hold limit of 8
        step(1, 16'h0000, 0, 1, 16'h0000, 0, 0, 0, "reset_b");
        for (int i = 0; i < 8; i++)
            step(0, 16'h0006, 0, 1, 16'h0002, 1, 1, 0, "t8_own1");
        step(0, 16'h0006, 0, 1, 16'h0000, 1, 0, 1, "t8_preempt1");
        step(0, 16'h0006, 0, 1, 16'h0004, 2, 1, 0, "t8_grant2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
